stack_row_controller: RTL
=========================

// Module: stack_row_controller
// PURPOSE
//   Player-side counterpart of the level FSM. Sweeps the active block row left/right at the
//   level's speed and captures the drop button. Judges overlap against the row below, then
//   issues go / next_signal. Consumes speed_count, num_blocks and curr_level; drives go and
//   next_signal back to the level FSM, plus row/stack state for the VGA drawer.
// PARAMETERS
//   FRAME_DIV  833333  clocks per 60 Hz frame tick (50 MHz); benches use 4
//   COLS       8       playfield width in columns (row mask width)
// PORTS
//   clk          in   1     system clock
//   resetn       in   1     reset, synchronous, active-high (despite the name)
//   drop_btn     in   1     synchronized drop button, level; rising edge = drop
//   speed_count  in   11    frame ticks per one-column move
//   num_blocks   in   4     width of a freshly loaded row
//   curr_level   in   6     current level 1..15
//   go           out  1     1-cycle pulse: row placed, level FSM may step
//   next_signal  out  1     1 = placement succeeded; valid in go cycle and the cycle after
//   row_mask     out  COLS  moving row, bit i = column i occupied
//   base_mask    out  COLS  settled row directly below the moving row
//   height       out  4     number of rows settled this game (0..15)
//   fail_pulse   out  1     1-cycle pulse on a miss (game over)
//   win_pulse    out  1     1-cycle pulse on success at curr_level==15
// BEHAVIOUR
//   Reset (sync, any state) values:
//     state=LOAD, go=0, next_signal=0, row_mask=0, base_mask={COLS{1}}, height=0,
//     fail/win=0, frame/move counters=0, direction=right, drop edge register=0.
//   Frame tick: free-running counter 0..FRAME_DIV-1; tick is 1 cycle when it wraps.
//   Effective speed: spd = (speed_count==0) ? 1 : speed_count.
//   Effective width: nb = clamp(num_blocks, 1, COLS).
//   FSM:
//     LOAD   : row_mask <= (1<<nb)-1 (columns 0..nb-1); dir=right; move cnt=0 -> MOVE.
//     MOVE   : each tick, move cnt++. At move cnt==spd-1, clear it and shift one column.
//              Bounce: if the shift would push a 1 off the edge, reverse dir and shift the
//              other way. nb==COLS never shifts.
//              Drop rising edge -> JUDGE; the shift is suppressed in the same cycle.
//     JUDGE  : ov = row_mask & base_mask. ov!=0 = success. 1 cycle -> REPORT.
//     REPORT : go=1, next_signal=success. -> HOLD.
//     HOLD   : go=0, next_signal held. 1 cycle for the level FSM to sample -> UPDATE.
//     UPDATE : next_signal=0.
//              success && curr_level!=15: base_mask<=ov, height++.
//              success && curr_level==15: win_pulse=1, base={COLS{1}}, height=0.
//              miss: fail_pulse=1, base={COLS{1}}, height=0.
//              -> LOAD.
//   Drop edges outside MOVE are ignored; a held button does not re-trigger.
//   Latency: drop edge -> go = 2 cycles (JUDGE, REPORT); go -> next LOAD = 3 cycles.
//   Inputs are sampled in LOAD and JUDGE/UPDATE only. Changes mid-MOVE take effect next row.
//   height saturates at 15 and is never incremented past it.
//   Reset during REPORT/HOLD aborts: go and next_signal are 0 on the next cycle.
// TESTING (FRAME_DIV=4)
//   Reset, nb=1, spd=1: row_mask 0x01 -> 0x02 every 4 clks; at 0x80 reverses to 0x40.
//   Drop with row 0x04, base 0xFF: go 1 cycle 2 clks later, next_signal=1 there and next clk;
//     base=0x04, height=1.
//   Base 0x04, drop at row 0x10: next_signal=0, fail_pulse, base=0xFF, height=0.
//   curr_level=15, hit: win_pulse, go with next_signal=1, base=0xFF, height=0.
//   speed_count=0 moves like 1; num_blocks=12 loads 0xFF and never shifts; held drop -> one go.
//   Assert resetn during HOLD: next cycle go=0, next_signal=0, base=0xFF, row_mask=0.

Source files
------------

// File: rtl/stack_row_controller_if.sv
// Signal bundle between the level FSM (master) and the stack row controller (slave).
// go is a one-cycle strobe with no back-pressure; next_signal is only meaningful while go is high and on the cycle after it.
interface stack_row_controller_if #(
  parameter int COLS = 8
);
  logic            drop_btn;
  logic [10:0]     speed_count;
  logic [3:0]      num_blocks;
  logic [5:0]      curr_level;
  logic            go;
  logic            next_signal;
  logic [COLS-1:0] row_mask;
  logic [COLS-1:0] base_mask;
  logic [3:0]      height;
  logic            fail_pulse;
  logic            win_pulse;

  modport master (
    output drop_btn, speed_count, num_blocks, curr_level,
    input  go, next_signal, row_mask, base_mask, height, fail_pulse, win_pulse
  );

  modport slave (
    input  drop_btn, speed_count, num_blocks, curr_level,
    output go, next_signal, row_mask, base_mask, height, fail_pulse, win_pulse
  );
endinterface

// File: rtl/stack_row_controller.sv
// Sweeps the active block row, captures the drop button, judges overlap with the row below
// and reports the result to the level FSM.
module stack_row_controller #(
  parameter int FRAME_DIV = 833333,
  parameter int COLS      = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  stack_row_controller_if.slave  bus,
  output logic [2:0]             state_dbg
);

  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    MOVE   = 3'd1,
    JUDGE  = 3'd2,
    REPORT = 3'd3,
    HOLD   = 3'd4,
    UPDATE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [10:0]     move_cnt_q, move_cnt_d;
  logic [10:0]     spd_q, spd_d;
  logic            dir_q, dir_d;
  logic            drop_q, drop_d;
  logic [COLS-1:0] row_q, row_d;
  logic [COLS-1:0] base_q, base_d;
  logic [COLS-1:0] ov_q, ov_d;
  logic            success_q, success_d;
  logic [3:0]      height_q, height_d;

  logic            tick;
  logic            drop_edge;
  logic [COLS-1:0] load_mask;
  int              nb_int;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= LOAD;
      frame_cnt_q <= '0;
      move_cnt_q  <= '0;
      spd_q       <= 11'd1;
      dir_q       <= 1'b1;
      drop_q      <= 1'b0;
      row_q       <= '0;
      base_q      <= '1;
      ov_q        <= '0;
      success_q   <= 1'b0;
      height_q    <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      move_cnt_q  <= move_cnt_d;
      spd_q       <= spd_d;
      dir_q       <= dir_d;
      drop_q      <= drop_d;
      row_q       <= row_d;
      base_q      <= base_d;
      ov_q        <= ov_d;
      success_q   <= success_d;
      height_q    <= height_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    move_cnt_d  = move_cnt_q;
    spd_d       = spd_q;
    dir_d       = dir_q;
    row_d       = row_q;
    base_d      = base_q;
    ov_d        = ov_q;
    success_d   = success_q;
    height_d    = height_q;

    tick        = (frame_cnt_q == FW'(FRAME_DIV - 1));
    frame_cnt_d = tick ? '0 : frame_cnt_q + FW'(1);
    drop_d      = bus.drop_btn;
    drop_edge   = bus.drop_btn & ~drop_q;

    nb_int = int'(bus.num_blocks);
    if (nb_int < 1)    nb_int = 1;
    if (nb_int > COLS) nb_int = COLS;
    for (int i = 0; i < COLS; i++) load_mask[i] = (i < nb_int);

    case (state_q)
      LOAD: begin
        row_d      = load_mask;
        dir_d      = 1'b1;
        move_cnt_d = '0;
        spd_d      = (bus.speed_count == 11'd0) ? 11'd1 : bus.speed_count;
        state_d    = MOVE;
      end
      MOVE: begin
        if (drop_edge) begin
          state_d = JUDGE;
        end else if (tick) begin
          if (move_cnt_q == spd_q - 11'd1) begin
            move_cnt_d = '0;
            // A full-width row touches both edges and has nowhere to go.
            if (!(row_q[0] && row_q[COLS-1])) begin
              if (dir_q) begin
                if (row_q[COLS-1]) begin
                  dir_d = 1'b0;
                  row_d = row_q >> 1;
                end else begin
                  row_d = row_q << 1;
                end
              end else begin
                if (row_q[0]) begin
                  dir_d = 1'b1;
                  row_d = row_q << 1;
                end else begin
                  row_d = row_q >> 1;
                end
              end
            end
          end else begin
            move_cnt_d = move_cnt_q + 11'd1;
          end
        end
      end
      JUDGE: begin
        ov_d      = row_q & base_q;
        success_d = |(row_q & base_q);
        state_d   = REPORT;
      end
      REPORT: state_d = HOLD;
      HOLD:   state_d = UPDATE;
      UPDATE: begin
        if (success_q && bus.curr_level != 6'd15) begin
          base_d   = ov_q;
          height_d = (height_q == 4'd15) ? 4'd15 : height_q + 4'd1;
        end else begin
          base_d   = '1;
          height_d = '0;
        end
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign bus.go          = (state_q == REPORT);
  assign bus.next_signal = ((state_q == REPORT) || (state_q == HOLD)) && success_q;
  assign bus.fail_pulse  = (state_q == UPDATE) && !success_q;
  assign bus.win_pulse   = (state_q == UPDATE) && success_q && (bus.curr_level == 6'd15);
  assign bus.row_mask    = row_q;
  assign bus.base_mask   = base_q;
  assign bus.height      = height_q;
  assign state_dbg       = state_q;

endmodule
